ecc_point_add_ctrl: RTL and testbench

ECC_POINT_ADD_CTRL -- requirements
Module: ecc_point_add_ctrl

---
 rtl/ecc_ctrl_pkg.sv | 45 ++++
 rtl/ecc_uop_rom.sv | 25 ++
 rtl/ecc_point_add_ctrl.sv | 152 +++++++++++++++
 tb/tb_ecc_point_add_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_ctrl_pkg.sv
// Shared encodings and register-file layout for the ECC point-addition controller.
package ecc_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MULT = 2'd2,
        OP_DIV  = 2'd3
    } op_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    localparam int NUM_STEPS       = 9;
    localparam int STEP_W          = 4;
    localparam int REG_IDX_W       = 4;
    localparam int NUM_REGS        = 13;
    localparam int DEFAULT_TIMEOUT = 1023;

    localparam logic [REG_IDX_W-1:0] R_X1 = 4'd0;
    localparam logic [REG_IDX_W-1:0] R_Y1 = 4'd1;
    localparam logic [REG_IDX_W-1:0] R_X2 = 4'd2;
    localparam logic [REG_IDX_W-1:0] R_Y2 = 4'd3;
    localparam logic [REG_IDX_W-1:0] R_T0 = 4'd4;
    localparam logic [REG_IDX_W-1:0] R_T1 = 4'd5;
    localparam logic [REG_IDX_W-1:0] R_T2 = 4'd6;
    localparam logic [REG_IDX_W-1:0] R_T3 = 4'd7;
    localparam logic [REG_IDX_W-1:0] R_T4 = 4'd8;
    localparam logic [REG_IDX_W-1:0] R_T5 = 4'd9;
    localparam logic [REG_IDX_W-1:0] R_L  = 4'd10;
    localparam logic [REG_IDX_W-1:0] R_X3 = 4'd11;
    localparam logic [REG_IDX_W-1:0] R_Y3 = 4'd12;

    typedef struct packed {
        op_sel_e                op;
        logic [REG_IDX_W-1:0]   src_a;
        logic [REG_IDX_W-1:0]   src_b;
        logic [REG_IDX_W-1:0]   dest;
    } uop_t;

endpackage

// File: rtl/ecc_uop_rom.sv
// Micro-program for affine point addition: step index -> GFAU op, sources, destination.
module ecc_uop_rom
    import ecc_ctrl_pkg::*;
(
    input  logic [STEP_W-1:0] step_i,
    output uop_t              uop_o
);

    always_comb begin
        uop_o = '{op: OP_SUB, src_a: R_Y2, src_b: R_Y1, dest: R_T0};
        case (step_i)
            4'd0: uop_o = '{op: OP_SUB,  src_a: R_Y2, src_b: R_Y1, dest: R_T0};
            4'd1: uop_o = '{op: OP_SUB,  src_a: R_X2, src_b: R_X1, dest: R_T1};
            4'd2: uop_o = '{op: OP_DIV,  src_a: R_T0, src_b: R_T1, dest: R_L };
            4'd3: uop_o = '{op: OP_MULT, src_a: R_L,  src_b: R_L,  dest: R_T2};
            4'd4: uop_o = '{op: OP_SUB,  src_a: R_T2, src_b: R_X1, dest: R_T3};
            4'd5: uop_o = '{op: OP_SUB,  src_a: R_T3, src_b: R_X2, dest: R_X3};
            4'd6: uop_o = '{op: OP_SUB,  src_a: R_X1, src_b: R_X3, dest: R_T4};
            4'd7: uop_o = '{op: OP_MULT, src_a: R_L,  src_b: R_T4, dest: R_T5};
            4'd8: uop_o = '{op: OP_SUB,  src_a: R_T5, src_b: R_Y1, dest: R_Y3};
            default: ;
        endcase
    end

endmodule

// File: rtl/ecc_point_add_ctrl.sv
// Sequences an external GF(p) arithmetic unit through P3 = P1 + P2 (affine, P1 != +-P2).
module ecc_point_add_ctrl
    import ecc_ctrl_pkg::*;
#(
    parameter int SIZE    = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [SIZE-1:0] i_x1,
    input  logic [SIZE-1:0] i_y1,
    input  logic [SIZE-1:0] i_x2,
    input  logic [SIZE-1:0] i_y2,
    input  logic [SIZE-1:0] i_prime,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic [SIZE-1:0] o_x3,
    output logic [SIZE-1:0] o_y3,
    output logic [SIZE-1:0] o_in_0,
    output logic [SIZE-1:0] o_in_1,
    output logic [SIZE-1:0] o_prime,
    output logic [1:0]      o_op_sel,
    output logic            o_done_from_control,
    input  logic [SIZE-1:0] i_result,
    input  logic            i_done_to_control
);

    localparam int TW = $clog2(TIMEOUT + 1) + 1;
    localparam logic [TW-1:0]     TO_LIM    = TW'(TIMEOUT);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [STEP_W-1:0] DX_STEP   = 4'd1;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [TW-1:0]     wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic [SIZE-1:0]   x3_q, x3_d;
    logic [SIZE-1:0]   y3_q, y3_d;
    logic [SIZE-1:0]   prime_q;
    logic [SIZE-1:0]   regs_q [NUM_REGS];
    logic              load_en;
    logic              wr_en;
    uop_t              uop;

    ecc_uop_rom u_rom (
        .step_i (step_q),
        .uop_o  (uop)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        x3_d    = x3_q;
        y3_d    = y3_q;
        load_en = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    load_en = 1'b1;
                    step_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_done_to_control) begin
                    wr_en = 1'b1;
                    // A zero x2-x1 means P1 == +-P2: the slope division is undefined.
                    if (step_q == DX_STEP && i_result == '0) begin
                        err_d   = 1'b1;
                        x3_d    = '0;
                        y3_d    = '0;
                        state_d = ST_FINISH;
                    end else if (step_q == LAST_STEP) begin
                        x3_d    = regs_q[R_X3];
                        y3_d    = i_result;
                        state_d = ST_FINISH;
                    end else begin
                        step_d  = step_q + 4'd1;
                        state_d = ST_ISSUE;
                    end
                end else if (wcnt_q == TO_LIM) begin
                    err_d   = 1'b1;
                    x3_d    = '0;
                    y3_d    = '0;
                    state_d = ST_FINISH;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            x3_q    <= '0;
            y3_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            x3_q    <= x3_d;
            y3_q    <= y3_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prime_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (load_en) begin
            prime_q      <= i_prime;
            regs_q[R_X1] <= i_x1;
            regs_q[R_Y1] <= i_y1;
            regs_q[R_X2] <= i_x2;
            regs_q[R_Y2] <= i_y2;
        end else if (wr_en) begin
            regs_q[uop.dest] <= i_result;
        end
    end

    // Operands stay driven through WAIT so the GFAU may sample them late.
    assign o_in_0              = (state_q == ST_ISSUE || state_q == ST_WAIT) ? regs_q[uop.src_a] : '0;
    assign o_in_1              = (state_q == ST_ISSUE || state_q == ST_WAIT) ? regs_q[uop.src_b] : '0;
    assign o_op_sel            = (state_q == ST_ISSUE || state_q == ST_WAIT) ? uop.op : OP_ADD;
    assign o_done_from_control = (state_q == ST_ISSUE);
    assign o_prime             = prime_q;
    assign o_busy              = (state_q != ST_IDLE);
    assign o_done              = (state_q == ST_FINISH);
    assign o_err               = err_q;
    assign o_x3                = x3_q;
    assign o_y3                = y3_q;

endmodule

// File: tb/tb_ecc_point_add_ctrl.sv
// Directed bench: a behavioural GF(p) unit answers the controller's issues.
module tb_ecc_point_add_ctrl;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        i_rst, i_start, i_done_to_control;
    logic [31:0] i_x1, i_y1, i_x2, i_y2, i_prime, i_result;
    logic        o_busy, o_done, o_err, o_done_from_control;
    logic [31:0] o_x3, o_y3, o_in_0, o_in_1, o_prime;
    logic [1:0]  o_op_sel;

    always #5 clk = ~clk;

    ecc_point_add_ctrl #(.SIZE(32), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
        .i_x1(i_x1), .i_y1(i_y1), .i_x2(i_x2), .i_y2(i_y2), .i_prime(i_prime),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_x3(o_x3), .o_y3(o_y3),
        .o_in_0(o_in_0), .o_in_1(o_in_1), .o_prime(o_prime),
        .o_op_sel(o_op_sel), .o_done_from_control(o_done_from_control),
        .i_result(i_result), .i_done_to_control(i_done_to_control)
    );

    int total = 0;
    int bad   = 0;

    int          n_iss, n_strobe_bad, n_stab_bad, t_issue1, t_done;
    bit          got_done;
    logic [31:0] r_x3, r_y3, a_log0, b_log0, prime_seen;
    logic        r_err;
    logic [1:0]  op_log [16];
    logic [1:0]  exp_ops [9] = '{2'd1, 2'd1, 2'd3, 2'd2, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};

    function automatic logic [31:0] gfau(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] p);
        longint unsigned la, lb, lp, r;
        la = a; lb = b; lp = p; r = 0;
        case (op)
            2'd0: r = (la + lb) % lp;
            2'd1: r = (la + lp - lb) % lp;
            2'd2: r = (la * lb) % lp;
            default: for (longint unsigned i = 1; i < lp; i++) if ((lb * i) % lp == 1) r = (la * i) % lp;
        endcase
        return r[31:0];
    endfunction

    task automatic do_start(input logic [31:0] x1, input logic [31:0] y1, input logic [31:0] x2,
                            input logic [31:0] y2, input logic [31:0] p);
        @(negedge clk);
        i_x1 = x1; i_y1 = y1; i_x2 = x2; i_y2 = y2; i_prime = p;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Plays the GFAU from the negedge after start until o_done, an abort point, or the cycle budget.
    task automatic serve(input int lat, input bit respond, input int abort_issue, input bit noise);
        bit pend, prev_str, noise_on;
        int cnt;
        logic [31:0] a, b;
        logic [1:0] op;
        pend = 0; prev_str = 0; noise_on = 0; cnt = 0; a = '0; b = '0; op = '0;
        n_iss = 0; n_strobe_bad = 0; n_stab_bad = 0; got_done = 0; t_issue1 = -1; t_done = -1;
        for (int c = 0; c < 3000; c++) begin
            i_done_to_control = 1'b0;
            if (noise_on) begin i_start = 1'b0; noise_on = 0; end
            if (o_done) begin
                got_done = 1; r_x3 = o_x3; r_y3 = o_y3; r_err = o_err; t_done = c;
                return;
            end
            if (o_done_from_control && prev_str) n_strobe_bad++;
            prev_str = o_done_from_control;
            if (o_done_from_control) begin
                if (pend) n_strobe_bad++;
                if (n_iss < 16) op_log[n_iss] = o_op_sel;
                if (n_iss == 0) begin
                    a_log0 = o_in_0; b_log0 = o_in_1; t_issue1 = c; prime_seen = o_prime;
                end
                n_iss++;
                a = o_in_0; b = o_in_1; op = o_op_sel; pend = 1; cnt = 0;
                if (noise && n_iss == 4) begin
                    i_start = 1'b1; i_x1 = 32'd7; i_y1 = 32'd1; i_prime = 32'd11; noise_on = 1;
                end
            end else if (pend) begin
                if (o_in_0 !== a || o_in_1 !== b || o_op_sel !== op) n_stab_bad++;
                cnt++;
                if (abort_issue != 0 && n_iss == abort_issue) return;
                if (respond && cnt == lat) begin
                    i_result = gfau(op, a, b, o_prime);
                    i_done_to_control = 1'b1;
                    pend = 0;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b1; i_done_to_control = 1'b0;
        i_x1 = 32'd3; i_y1 = 32'd6; i_x2 = 32'd80; i_y2 = 32'd10; i_prime = 32'd97; i_result = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({o_busy, o_done, o_err, o_done_from_control, o_op_sel} !== 6'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000", {o_busy, o_done, o_err, o_done_from_control, o_op_sel});
        end
        total++;
        if ({o_x3, o_y3, o_in_0, o_in_1, o_prime} !== 160'd0) begin
            bad++;
            $display("FAIL reset_data: got x3=%0d y3=%0d in0=%0d in1=%0d p=%0d want all 0",
                     o_x3, o_y3, o_in_0, o_in_1, o_prime);
        end
        i_rst = 1'b0; i_start = 1'b0;
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0) begin
            bad++; $display("FAIL start_in_reset_dropped: busy=%b want 0", o_busy);
        end
    endtask

    task automatic test_add();
        do_start(32'd3, 32'd6, 32'd80, 32'd10, 32'd97);
        serve(2, 1, 0, 0);
        total++;
        if (got_done !== 1'b1) begin bad++; $display("FAIL add_done: got %0d want 1", got_done); end
        total++;
        if (n_iss !== 9) begin bad++; $display("FAIL add_issues: got %0d want 9", n_iss); end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (op_log[i] !== exp_ops[i]) begin
                bad++; $display("FAIL add_op%0d: got %0d want %0d", i, op_log[i], exp_ops[i]);
            end
        end
        total++;
        if ({a_log0, b_log0, prime_seen} !== {32'd10, 32'd6, 32'd97}) begin
            bad++; $display("FAIL add_first_operands: got %0d,%0d p=%0d want 10,6 p=97", a_log0, b_log0, prime_seen);
        end
        total++;
        if (r_x3 !== 32'd80) begin bad++; $display("FAIL add_x3: got %0d want 80", r_x3); end
        total++;
        if (r_y3 !== 32'd87) begin bad++; $display("FAIL add_y3: got %0d want 87", r_y3); end
        total++;
        if (r_err !== 1'b0) begin bad++; $display("FAIL add_err: got %0d want 0", r_err); end
        total++;
        if (n_stab_bad !== 0) begin bad++; $display("FAIL add_stable: got %0d unstable cycles want 0", n_stab_bad); end
        total++;
        if (n_strobe_bad !== 0) begin bad++; $display("FAIL add_strobe: got %0d bad strobes want 0", n_strobe_bad); end
        total++;
        if (t_done !== 27) begin bad++; $display("FAIL add_latency: got %0d want 27", t_done); end
        repeat (3) @(negedge clk);
        total++;
        if ({o_done, o_busy, o_x3, o_y3} !== {1'b0, 1'b0, 32'd80, 32'd87}) begin
            bad++; $display("FAIL add_hold: got done=%b busy=%b x3=%0d y3=%0d want 0 0 80 87", o_done, o_busy, o_x3, o_y3);
        end
    endtask

    task automatic test_mid_reset();
        do_start(32'd3, 32'd6, 32'd80, 32'd10, 32'd97);
        serve(2, 1, 5, 0);
        total++;
        if (o_busy !== 1'b1 || o_op_sel !== 2'd1) begin
            bad++; $display("FAIL midrst_in_step4: busy=%b op=%0d want 1 1", o_busy, o_op_sel);
        end
        i_rst = 1'b1;
        @(negedge clk);
        total++;
        if ({o_busy, o_done, o_err, o_done_from_control, o_op_sel, o_x3, o_y3, o_in_0, o_in_1, o_prime} !== '0) begin
            bad++; $display("FAIL midrst_outputs: busy=%b x3=%0d y3=%0d in0=%0d p=%0d want all 0",
                            o_busy, o_x3, o_y3, o_in_0, o_prime);
        end
        i_rst = 1'b0;
        do_start(32'd3, 32'd6, 32'd80, 32'd10, 32'd97);
        serve(1, 1, 0, 0);
        total++;
        if ({got_done, r_err, r_x3, r_y3} !== {1'b1, 1'b0, 32'd80, 32'd87}) begin
            bad++; $display("FAIL midrst_rerun: done=%0d err=%0d x3=%0d y3=%0d want 1 0 80 87", got_done, r_err, r_x3, r_y3);
        end
        total++;
        if (t_done !== 18) begin bad++; $display("FAIL midrst_latency: got %0d want 18", t_done); end
    endtask

    task automatic test_ignore();
        @(negedge clk);
        i_result = 32'd55; i_done_to_control = 1'b1;
        repeat (2) @(negedge clk);
        i_done_to_control = 1'b0;
        total++;
        if ({o_busy, o_done, o_done_from_control, o_x3} !== {3'b000, 32'd80}) begin
            bad++; $display("FAIL idle_spurious_done: busy=%b done=%b x3=%0d want 0 0 80", o_busy, o_done, o_x3);
        end
        do_start(32'd3, 32'd6, 32'd80, 32'd10, 32'd97);
        serve(1, 1, 0, 1);
        total++;
        if (n_iss !== 9) begin bad++; $display("FAIL restart_issues: got %0d want 9", n_iss); end
        total++;
        if ({got_done, r_err, r_x3, r_y3} !== {1'b1, 1'b0, 32'd80, 32'd87}) begin
            bad++; $display("FAIL restart_result: done=%0d err=%0d x3=%0d y3=%0d want 1 0 80 87", got_done, r_err, r_x3, r_y3);
        end
    endtask

    task automatic test_equal_x();
        do_start(32'd5, 32'd6, 32'd5, 32'd10, 32'd97);
        serve(1, 1, 0, 0);
        total++;
        if (n_iss !== 2) begin bad++; $display("FAIL eqx_issues: got %0d want 2", n_iss); end
        total++;
        if ({op_log[0], op_log[1]} !== 4'b0101) begin
            bad++; $display("FAIL eqx_ops: got %0d,%0d want 1,1", op_log[0], op_log[1]);
        end
        total++;
        if ({got_done, r_err} !== 2'b11) begin bad++; $display("FAIL eqx_err: done=%0d err=%0d want 1 1", got_done, r_err); end
        total++;
        if ({r_x3, r_y3} !== 64'd0) begin bad++; $display("FAIL eqx_zero: x3=%0d y3=%0d want 0 0", r_x3, r_y3); end
    endtask

    task automatic test_timeout();
        do_start(32'd3, 32'd6, 32'd80, 32'd10, 32'd97);
        serve(1, 0, 0, 0);
        total++;
        if ({got_done, r_err} !== 2'b11) begin bad++; $display("FAIL to_err: done=%0d err=%0d want 1 1", got_done, r_err); end
        total++;
        if (n_iss !== 1) begin bad++; $display("FAIL to_issues: got %0d want 1", n_iss); end
        total++;
        if (t_done - t_issue1 !== TO + 2) begin
            bad++; $display("FAIL to_cycles: got %0d want %0d", t_done - t_issue1, TO + 2);
        end
        total++;
        if ({r_x3, r_y3} !== 64'd0) begin bad++; $display("FAIL to_zero: x3=%0d y3=%0d want 0 0", r_x3, r_y3); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mid_reset();
        test_ignore();
        test_equal_x();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
